// File: rtl/stepgen_cmd_ctrl.sv
// Command/configuration controller between EPP register decode and four stepgen channels.
// Shadowed velocities with atomic commit, config interlock and a host-kicked watchdog.
module stepgen_cmd_ctrl #(
    parameter int                 F        = 11,
    parameter int                 T        = 4,
    parameter int                 WDT_W    = 8,
    parameter logic [WDT_W-1:0]   WDT_LOAD = 8'd200
) (
    input  logic                 clk,
    input  logic                 nReset,
    input  logic                 wr_en,
    input  logic [3:0]           wr_addr,
    input  logic [15:0]          wr_data,
    input  logic                 tick_in,
    output logic [4*(F+1)-1:0]   vel_flat,
    output logic [T-1:0]         steptime,
    output logic [T-1:0]         dirtime,
    output logic [1:0]           tap,
    output logic                 spolarity,
    output logic [13:0]          dout,
    output logic                 tristate,
    output logic [1:0]           wdt_state,
    output logic                 cfg_reject
);
    localparam int VW = F + 1;
    localparam logic [WDT_W-1:0] CNT_ONE = {{(WDT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        WDT_DISABLED = 2'd0,
        WDT_ARMED    = 2'd1,
        WDT_EXPIRED  = 2'd2
    } wdt_state_e;

    wdt_state_e         state_q, state_d;
    logic [WDT_W-1:0]   cnt_q, cnt_d;
    logic [4*VW-1:0]    shadow_q, shadow_d;
    logic [4*VW-1:0]    vel_q, vel_d;
    logic [T-1:0]       steptime_q, steptime_d;
    logic [T-1:0]       dirtime_q, dirtime_d;
    logic [1:0]         tap_q, tap_d;
    logic               spol_q, spol_d;
    logic [13:0]        dout_q, dout_d;
    logic               cfg_reject_q, cfg_reject_d;

    logic               commit;
    logic               kick;
    logic               cfg_wr;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q      <= WDT_DISABLED;
            cnt_q        <= '0;
            shadow_q     <= '0;
            vel_q        <= '0;
            steptime_q   <= '0;
            dirtime_q    <= '0;
            tap_q        <= '0;
            spol_q       <= 1'b0;
            dout_q       <= '0;
            cfg_reject_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shadow_q     <= shadow_d;
            vel_q        <= vel_d;
            steptime_q   <= steptime_d;
            dirtime_q    <= dirtime_d;
            tap_q        <= tap_d;
            spol_q       <= spol_d;
            dout_q       <= dout_d;
            cfg_reject_q <= cfg_reject_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shadow_d     = shadow_q;
        vel_d        = vel_q;
        steptime_d   = steptime_q;
        dirtime_d    = dirtime_q;
        tap_d        = tap_q;
        spol_d       = spol_q;
        dout_d       = dout_q;
        cfg_reject_d = 1'b0;

        commit = wr_en && (wr_addr == 4'd9);
        kick   = commit && wr_data[14];
        cfg_wr = wr_en && (wr_addr == 4'd11);

        if (wr_en) begin
            case (wr_addr)
                4'd1:    shadow_d[0*VW +: VW] = wr_data[F:0];
                4'd3:    shadow_d[1*VW +: VW] = wr_data[F:0];
                4'd5:    shadow_d[2*VW +: VW] = wr_data[F:0];
                4'd7:    shadow_d[3*VW +: VW] = wr_data[F:0];
                default: ;
            endcase
        end

        // Interlock looks at the velocities currently driving the channels.
        if (cfg_wr) begin
            if (vel_q == '0) begin
                steptime_d = wr_data[T-1:0];
                tap_d      = wr_data[7:6];
                dirtime_d  = wr_data[8+T-1:8];
                spol_d     = wr_data[15];
            end else begin
                cfg_reject_d = 1'b1;
            end
        end

        if (commit) begin
            dout_d = wr_data[13:0];
            if (kick || (state_q != WDT_EXPIRED)) begin
                vel_d = shadow_q;
            end
        end

        // A kick overrides both a same-edge tick and a same-edge expiry.
        if (kick) begin
            state_d = WDT_ARMED;
            cnt_d   = WDT_LOAD;
        end else if ((state_q == WDT_ARMED) && tick_in) begin
            if (cnt_q == '0) begin
                state_d = WDT_EXPIRED;
                vel_d   = '0;
            end else begin
                cnt_d = cnt_q - CNT_ONE;
            end
        end
    end

    assign vel_flat   = vel_q;
    assign steptime   = steptime_q;
    assign dirtime    = dirtime_q;
    assign tap        = tap_q;
    assign spolarity  = spol_q;
    assign dout       = dout_q;
    assign tristate   = (state_q == WDT_EXPIRED);
    assign wdt_state  = state_q;
    assign cfg_reject = cfg_reject_q;

endmodule
